// File: rtl/npu_cluster_dispatch.sv
// -----------------------------------------------------------------------------
// npu_cluster_dispatch
//
// Host-facing front end for a cluster of NUM_TILES NPU tiles. It decodes one
// MMIO window into per-tile pass-through accesses and a small bank of cluster
// CSRs. It also owns a job FIFO whose command words go to the lowest-index
// idle tile, tracks busy/done per tile, raises irq, and supplies a runtime
// precision mode for each tile.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   host_addr       [AW-1]=1 selects a cluster CSR (word index in [2:0]);
//                   [AW-1]=0 selects tile [TILE_AW+:TSW] at offset [TILE_AW-1:0]
//   host_wr_data    host write data
//   host_wr_en      host write strobe, one cycle per write
//   host_rd_data    combinational read data for host_addr
//   irq             |(done & irq_en)
//   tile_addr       shared tile address bus (registered)
//   tile_wr_data    shared tile write data (registered)
//   tile_wr_en      one-hot tile write strobe (registered)
//   tile_rd_data    per-tile combinational read data, tile t at [t*DW+:DW]
//   tile_all_done   per-tile level done indication
//   tile_precision  per-tile precision mode, tile t at [2t+1:2t]
//
// CSR map (word index)
//   0 CTRL     W   bit0: flush FIFO, clear done and overflow
//   1 STATUS   RO  [7:0] done, [15:8] busy, [16] overflow, [27:24] fifo count
//   2 PUSH     WO  enqueue a command word
//   3 DONE_CLR W1C on done
//   4 PREC     RW  per-tile precision mode
//   5 IRQ_EN   RW  per-tile irq enable
// -----------------------------------------------------------------------------
`ifndef MMIO_ADDR_WIDTH
`define MMIO_ADDR_WIDTH 8
`endif
`ifndef HOST_DATA_WIDTH
`define HOST_DATA_WIDTH 32
`endif

module npu_cluster_dispatch #(
  parameter int NUM_TILES   = 4,
  parameter int TILE_AW     = `MMIO_ADDR_WIDTH,
  parameter int DW          = `HOST_DATA_WIDTH,
  parameter int QUEUE_DEPTH = 8,
  parameter int CMD_ADDR    = 0,
  localparam int TSW        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
  localparam int AW         = TILE_AW + TSW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AW-1:0]           host_addr,
  input  logic [DW-1:0]           host_wr_data,
  input  logic                    host_wr_en,
  output logic [DW-1:0]           host_rd_data,
  output logic                    irq,
  output logic [TILE_AW-1:0]      tile_addr,
  output logic [DW-1:0]           tile_wr_data,
  output logic [NUM_TILES-1:0]    tile_wr_en,
  input  logic [NUM_TILES*DW-1:0] tile_rd_data,
  input  logic [NUM_TILES-1:0]    tile_all_done,
  output logic [2*NUM_TILES-1:0]  tile_precision
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = 4;  // holds 0..15 entries
  localparam logic [2*NUM_TILES-1:0] PREC_RST = {NUM_TILES{2'b10}};
  localparam logic [TILE_AW-1:0]     CMD_OFF  = TILE_AW'(CMD_ADDR);

  typedef enum logic [2:0] {
    CSR_CTRL     = 3'd0,
    CSR_STATUS   = 3'd1,
    CSR_PUSH     = 3'd2,
    CSR_DONE_CLR = 3'd3,
    CSR_PREC     = 3'd4,
    CSR_IRQ_EN   = 3'd5
  } csr_e;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_TILES-1:0]   tile_wr_en_q,      tile_wr_en_d;
  logic [TILE_AW-1:0]     tile_addr_q,       tile_addr_d;
  logic [DW-1:0]          tile_wr_data_q,    tile_wr_data_d;
  logic [PW-1:0]          rd_ptr_q,          rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q,          wr_ptr_d;
  logic [CW-1:0]          count_q,           count_d;
  logic [NUM_TILES-1:0]   busy_q,            busy_d;
  logic [NUM_TILES-1:0]   done_q,            done_d;
  logic                   overflow_q,        overflow_d;
  logic [NUM_TILES-1:0]   irq_en_q,          irq_en_d;
  logic [2*NUM_TILES-1:0] prec_q,            prec_d;
  logic [NUM_TILES-1:0]   all_done_prev_q,   all_done_prev_d;

  logic [DW-1:0] fifo_mem_q [QUEUE_DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode and per-cycle events
  // ---------------------------------------------------------------------------
  logic                 csr_sel;
  csr_e                 csr_idx;
  logic [TSW-1:0]       tile_sel;
  logic [TILE_AW-1:0]   tile_off;
  logic                 tile_sel_ok;
  logic                 csr_wr, flush, push_req, push_ok, pop, host_tile_wr;
  logic [NUM_TILES-1:0] disp_oh, rise, busy_set;

  assign csr_sel     = host_addr[AW-1];
  assign csr_idx     = csr_e'(host_addr[2:0]);
  assign tile_sel    = host_addr[TILE_AW +: TSW];
  assign tile_off    = host_addr[TILE_AW-1:0];
  assign tile_sel_ok = (int'(tile_sel) < NUM_TILES);

  always_comb begin
    csr_wr       = host_wr_en & csr_sel;
    flush        = csr_wr && (csr_idx == CSR_CTRL) && host_wr_data[0];
    push_req     = csr_wr && (csr_idx == CSR_PUSH);
    host_tile_wr = host_wr_en && !csr_sel && tile_sel_ok;
    // Lowest clear bit of busy: adding one ripples through the trailing ones
    // and lands on the first idle tile; all-busy wraps to zero.
    disp_oh      = ~busy_q & (busy_q + 1'b1);
    // The host owns the tile bus this cycle if it writes a tile; a flush
    // discards the queue, so nothing is popped either.
    pop          = (count_q != '0) && (disp_oh != '0) && !host_tile_wr && !flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok      = push_req && !flush && ((count_q < CW'(QUEUE_DEPTH)) || pop);
    rise         = tile_all_done & ~all_done_prev_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    tile_wr_en_d    = '0;
    tile_addr_d     = tile_addr_q;
    tile_wr_data_d  = tile_wr_data_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    done_d          = done_q;
    overflow_d      = overflow_q;
    irq_en_d        = irq_en_q;
    prec_d          = prec_q;
    all_done_prev_d = tile_all_done;

    if (host_tile_wr) begin
      for (int t = 0; t < NUM_TILES; t++) begin
        tile_wr_en_d[t] = (int'(tile_sel) == t);
      end
      tile_addr_d    = tile_off;
      tile_wr_data_d = host_wr_data;
    end else if (pop) begin
      tile_wr_en_d   = disp_oh;
      tile_addr_d    = CMD_OFF;
      tile_wr_data_d = fifo_mem_q[rd_ptr_q];
    end

    // Any write to the command register starts the tile, whoever issued it.
    busy_set = (tile_addr_d == CMD_OFF) ? tile_wr_en_d : '0;
    // A start in the same cycle as a done rise wins: the new job is running.
    busy_d   = (busy_q & ~rise) | busy_set;

    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      done_d     = '0;
    end else begin
      if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d = count_q + CW'(push_ok) - CW'(pop);
      if (push_req && !push_ok) overflow_d = 1'b1;
    end

    if (csr_wr && (csr_idx == CSR_DONE_CLR)) done_d = done_d & ~host_wr_data[NUM_TILES-1:0];
    if (csr_wr && (csr_idx == CSR_PREC))     prec_d = host_wr_data[2*NUM_TILES-1:0];
    if (csr_wr && (csr_idx == CSR_IRQ_EN))   irq_en_d = host_wr_data[NUM_TILES-1:0];
    // A completion arriving with a clear is kept rather than lost.
    done_d = done_d | rise;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_wr_en_q    <= '0;
      tile_addr_q     <= '0;
      tile_wr_data_q  <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      busy_q          <= '0;
      done_q          <= '0;
      overflow_q      <= 1'b0;
      irq_en_q        <= '0;
      prec_q          <= PREC_RST;
      all_done_prev_q <= '0;
    end else begin
      tile_wr_en_q    <= tile_wr_en_d;
      tile_addr_q     <= tile_addr_d;
      tile_wr_data_q  <= tile_wr_data_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      overflow_q      <= overflow_d;
      irq_en_q        <= irq_en_d;
      prec_q          <= prec_d;
      all_done_prev_q <= all_done_prev_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count define which
  // entries are valid, so a reset only needs to clear those.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= host_wr_data;
  end

  // ---------------------------------------------------------------------------
  // Host read mux and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    host_rd_data = '0;
    if (csr_sel) begin
      case (csr_idx)
        CSR_STATUS: begin
          host_rd_data[NUM_TILES-1:0]   = done_q;
          host_rd_data[8 +: NUM_TILES]  = busy_q;
          host_rd_data[16]              = overflow_q;
          host_rd_data[24 +: CW]        = count_q;
        end
        CSR_PREC:   host_rd_data[2*NUM_TILES-1:0] = prec_q;
        CSR_IRQ_EN: host_rd_data[NUM_TILES-1:0]   = irq_en_q;
        default:    host_rd_data = '0;
      endcase
    end else begin
      for (int t = 0; t < NUM_TILES; t++) begin
        if (int'(tile_sel) == t) host_rd_data = tile_rd_data[t*DW +: DW];
      end
    end
  end

  assign tile_wr_en     = tile_wr_en_q;
  assign tile_addr      = tile_addr_q;
  assign tile_wr_data   = tile_wr_data_q;
  assign tile_precision = prec_q;
  assign irq            = |(done_q & irq_en_q);

endmodule

// File: tb/tb_npu_cluster_dispatch.sv
// -----------------------------------------------------------------------------
// tb_npu_cluster_dispatch
//
// Drives npu_cluster_dispatch (4 tiles, 8-bit tile window, 8-deep FIFO) with
// directed sequences followed by a randomized phase. A behavioural model
// (a job queue plus per-tile busy/done flags) predicts every tile write; the
// predictions go into a queue that a separate negedge monitor drains whenever
// the DUT drives a tile strobe.
// -----------------------------------------------------------------------------
module tb_npu_cluster_dispatch;

  localparam int NT  = 4;
  localparam int TAW = 8;
  localparam int AW  = TAW + 2 + 1;
  localparam int QD  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     host_addr;
  logic [31:0]       host_wr_data;
  logic              host_wr_en;
  logic [31:0]       host_rd_data;
  logic              irq;
  logic [TAW-1:0]    tile_addr;
  logic [31:0]       tile_wr_data;
  logic [NT-1:0]     tile_wr_en;
  logic [NT*32-1:0]  tile_rd_data;
  logic [NT-1:0]     tile_all_done;
  logic [2*NT-1:0]   tile_precision;

  npu_cluster_dispatch #(
    .NUM_TILES(NT), .TILE_AW(TAW), .DW(32), .QUEUE_DEPTH(QD), .CMD_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst),
    .host_addr(host_addr), .host_wr_data(host_wr_data), .host_wr_en(host_wr_en),
    .host_rd_data(host_rd_data), .irq(irq),
    .tile_addr(tile_addr), .tile_wr_data(tile_wr_data), .tile_wr_en(tile_wr_en),
    .tile_rd_data(tile_rd_data), .tile_all_done(tile_all_done),
    .tile_precision(tile_precision)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic [3:0]  en;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mq[$];
  logic [3:0]  m_busy, m_done, m_irq_en, m_prev;
  logic        m_ovf;
  logic [7:0]  m_prec;
  logic [3:0]  g_ad;

  function automatic logic [AW-1:0] csr_a(input int idx);
    return {1'b1, 7'b0, idx[2:0]};
  endfunction

  function automatic logic [AW-1:0] tile_a(input int t, input int off);
    return {1'b0, t[1:0], off[7:0]};
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    if (!a[AW-1]) return tile_rd_data[int'(a[9:8])*32 +: 32];
    case (a[2:0])
      3'd1:    return {4'b0, 4'(mq.size()), 7'b0, m_ovf, 4'b0, m_busy, 4'b0, m_done};
      3'd4:    return {24'b0, m_prec};
      3'd5:    return {28'b0, m_irq_en};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] adn);
    logic [3:0] set, rise;
    logic       is_csr, flush;
    wr_t        e;
    int         k;
    if (r) begin
      mq.delete();
      m_busy = '0; m_done = '0; m_irq_en = '0; m_ovf = 1'b0; m_prev = '0;
      m_prec = 8'hAA;
      return;
    end
    set    = '0;
    is_csr = a[AW-1];
    flush  = w && is_csr && (a[2:0] == 3'd0) && d[0];
    if (w && !is_csr) begin
      e.due = cyc + 1; e.en = 4'b1 << a[9:8]; e.addr = a[7:0]; e.data = d;
      exp_q.push_back(e);
      if (a[7:0] == 8'd0) set = e.en;
    end else if (!flush && mq.size() > 0 && m_busy != 4'hF) begin
      k = 0;
      while (m_busy[k]) k++;
      e.due = cyc + 1; e.en = 4'b1 << k; e.addr = 8'd0; e.data = mq.pop_front();
      exp_q.push_back(e);
      set = e.en;
    end
    if (flush) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_done = '0;
    end else if (w && is_csr && a[2:0] == 3'd2) begin
      if (mq.size() < QD) mq.push_back(d);
      else                m_ovf = 1'b1;
    end
    if (w && is_csr && a[2:0] == 3'd3) m_done   = m_done & ~d[3:0];
    if (w && is_csr && a[2:0] == 3'd4) m_prec   = d[7:0];
    if (w && is_csr && a[2:0] == 3'd5) m_irq_en = d[3:0];
    rise   = adn & ~m_prev;
    m_prev = adn;
    m_busy = (m_busy & ~rise) | set;
    m_done = m_done | rise;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers: one call = one clock cycle of inputs
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [3:0] adn, input logic rc);
    @(posedge clk);
    #1;
    rst = r; host_wr_en = w; host_addr = a; host_wr_data = d;
    tile_all_done = adn; g_ad = adn;
    #1;
    if (armed) begin
      if (rc) check("host_rd", host_rd_data, model_read(a));
      check("irq", irq, |(m_done & m_irq_en));
      check("tile_precision", tile_precision, m_prec);
    end
    model_step(r, w, a, d, adn);
    if (r) armed = 1'b1;
  endtask

  task automatic idle();                               step(0, 0, '0, '0, g_ad, 0); endtask
  task automatic rd(input logic [AW-1:0] a);           step(0, 0, a, '0, g_ad, 1); endtask
  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d); step(0, 1, a, d, g_ad, 0); endtask
  task automatic set_done(input logic [3:0] v);        step(0, 0, '0, '0, v, 0); endtask
  task automatic do_reset();                           step(1, 0, '0, '0, g_ad, 0); endtask

  // ---------------------------------------------------------------------------
  // Monitor: every tile strobe must match the oldest prediction, on time
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    wr_t e;
    if (armed) begin
      if (tile_wr_en !== '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tile_wr", {tile_wr_en, tile_addr, tile_wr_data}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("tile_wr_cycle", 64'(cyc), 64'(e.due));
          check("tile_wr", {tile_wr_en, tile_addr, tile_wr_data}, {e.en, e.addr, e.data});
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("missing_tile_wr", 64'(tile_wr_en), 64'(e.en));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int r;
    logic [3:0] adn;
    rst = 1'b1; host_wr_en = 1'b0; host_addr = '0; host_wr_data = '0;
    tile_all_done = '0; g_ad = '0;
    for (int t = 0; t < NT; t++) tile_rd_data[t*32 +: 32] = $urandom;

    // Reset state
    do_reset(); do_reset();
    rd(csr_a(1));
    check("status_after_reset", host_rd_data, 32'h0);
    rd(csr_a(4));
    check("prec_after_reset", host_rd_data, 32'hAA);
    check("irq_after_reset", irq, 1'b0);

    // Tile pass-through write and read
    wr(tile_a(2, 5), 32'h1234);
    idle();
    rd(tile_a(2, 5));
    rd(tile_a(3, 9));

    // Five jobs, four idle tiles: the fifth waits for tile 1 to finish
    for (int i = 0; i < 5; i++) wr(csr_a(2), $urandom);
    repeat (3) idle();
    rd(csr_a(1));
    check("status_one_queued", host_rd_data, 32'h0100_0F00);
    set_done(4'b0010);
    repeat (2) idle();
    rd(csr_a(1));
    check("status_after_tile1_done", host_rd_data, 32'h0000_0F02);

    // Overflow with every tile busy, then drain in two rounds
    set_done(4'b0000);
    wr(csr_a(0), 32'h1);
    for (int i = 0; i < QD + 1; i++) wr(csr_a(2), $urandom);
    rd(csr_a(1));
    check("status_overflow", host_rd_data, 32'h0801_0F00);
    set_done(4'b1111);
    repeat (5) idle();
    set_done(4'b0000);
    idle();
    set_done(4'b1111);
    repeat (5) idle();
    rd(csr_a(1));

    // Host tile write collides with a ready dispatch
    set_done(4'b0000);
    wr(csr_a(2), $urandom);
    set_done(4'b1000);
    wr(tile_a(0, 3), $urandom);
    repeat (3) idle();

    // Interrupt enable, done, clear
    wr(csr_a(3), 32'hF);
    wr(csr_a(5), 32'h1);
    set_done(4'b0000);
    set_done(4'b0001);
    idle();
    check("irq_on_tile0_done", irq, 1'b1);
    wr(csr_a(3), 32'h1);
    idle();
    check("irq_after_done_clr", irq, 1'b0);

    // Reset with jobs queued
    set_done(4'b0000);
    for (int i = 0; i < 4; i++) wr(csr_a(2), $urandom);
    do_reset();
    repeat (4) idle();
    rd(csr_a(1));
    check("fifo_count_after_reset", host_rd_data[27:24], 4'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 99);
      adn = g_ad;
      if ($urandom_range(0, 7) == 0) adn = 4'($urandom);
      if (r < 30)      step(0, 1, csr_a(2), $urandom, adn, 0);
      else if (r < 40) step(0, 1, tile_a($urandom_range(0, 3),
                                         ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 255)),
                            $urandom, adn, 0);
      else if (r < 43) step(0, 1, csr_a(3), 32'($urandom_range(0, 15)), adn, 0);
      else if (r < 46) step(0, 1, csr_a(5), 32'($urandom_range(0, 15)), adn, 0);
      else if (r < 48) step(0, 1, csr_a(4), $urandom, adn, 0);
      else if (r < 50) step(0, 1, csr_a($urandom_range(0, 7)), $urandom, adn, 0);
      else if (r < 72) step(0, 0, ($urandom_range(0, 1) == 1) ? csr_a($urandom_range(0, 7))
                                                             : tile_a($urandom_range(0, 3), $urandom_range(0, 255)),
                            '0, adn, 1);
      else             step(0, 0, '0, '0, adn, 0);
    end

    repeat (10) idle();
    rd(csr_a(1));
    check("expected_writes_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
